// File: rtl/clock_time_controller.sv
// Time-of-day counters, alarm-time registers and alarm sequencer for the VGA clock.
// Arbitrates the 1 Hz tick against the adjust buttons and generates the beeping buzzer tone.
module clock_time_controller #(
  parameter int RING_SECONDS = 60,
  parameter int AL_MIN_STEP  = 10,
  parameter int HOURS_MOD    = 12
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sec_tick,
  input  logic       tone_pulse,
  input  logic       sec_adj,
  input  logic       min_adj,
  input  logic       hrs_adj,
  input  logic       al_adj,
  input  logic       al_toggle,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [3:0] hours,
  output logic [5:0] al_minutes,
  output logic [3:0] al_hours,
  output logic       al_on,
  output logic       alarm_ringing,
  output logic       buzzer_out
);

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2
  } alarm_state_t;

  localparam logic [5:0] RING_LAST = 6'(RING_SECONDS - 1);
  localparam logic [3:0] HRS_LAST  = 4'(HOURS_MOD - 1);
  localparam logic [6:0] AL_STEP   = 7'(AL_MIN_STEP);

  alarm_state_t state;
  logic [5:0]   ring_cnt;
  logic         beep_phase;
  logic         tone;
  logic         match_prev;

  logic       sec_inc, sec_carry;
  logic       min_inc, min_carry;
  logic       hrs_inc;
  logic       match;
  logic [6:0] al_sum;
  logic       al_wrap;

  // Only a real tick ripples upward; an adjust-only wrap stays local to its field.
  assign sec_inc   = sec_tick | sec_adj;
  assign sec_carry = sec_tick && (seconds == 6'd59);
  assign min_inc   = min_adj | sec_carry;
  assign min_carry = sec_carry && (minutes == 6'd59);
  assign hrs_inc   = hrs_adj | min_carry;

  assign al_sum  = {1'b0, al_minutes} + AL_STEP;
  assign al_wrap = (al_sum >= 7'd60);

  assign match = (hours == al_hours) && (minutes == al_minutes) && (seconds == 6'd0);

  // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seconds    <= '0;
      minutes    <= '0;
      hours      <= '0;
      al_minutes <= '0;
      al_hours   <= '0;
    end else begin
      if (sec_inc) seconds <= (seconds == 6'd59) ? 6'd0 : seconds + 6'd1;
      if (min_inc) minutes <= (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
      if (hrs_inc) hours   <= (hours == HRS_LAST) ? 4'd0 : hours + 4'd1;
      if (al_adj) begin
        if (al_wrap) begin
          al_minutes <= 6'(al_sum - 7'd60);
          al_hours   <= (al_hours == HRS_LAST) ? 4'd0 : al_hours + 4'd1;
        end else begin
          al_minutes <= al_sum[5:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_OFF;
      ring_cnt   <= '0;
      beep_phase <= 1'b0;
      tone       <= 1'b0;
      match_prev <= 1'b0;
    end else begin
      match_prev <= match;

      unique case (state)
        ST_OFF: begin
          if (al_toggle) state <= ST_ARMED;
        end
        ST_ARMED: begin
          if (al_toggle) begin
            state <= ST_OFF;
          end else if (match && !match_prev) begin
            state      <= ST_RINGING;
            ring_cnt   <= '0;
            beep_phase <= 1'b1;
          end
        end
        ST_RINGING: begin
          if (al_toggle) begin
            state <= ST_OFF;
          end else if (sec_tick) begin
            if (ring_cnt == RING_LAST) begin
              state <= ST_ARMED;
            end else begin
              ring_cnt   <= ring_cnt + 6'd1;
              beep_phase <= ~beep_phase;
            end
          end
        end
        default: state <= ST_OFF;
      endcase

      // Tone halves tone_pulse during the "on" second and is held silent otherwise.
      if ((state == ST_RINGING) && beep_phase) begin
        if (tone_pulse) tone <= ~tone;
      end else begin
        tone <= 1'b0;
      end
    end
  end

  assign al_on         = (state != ST_OFF);
  assign alarm_ringing = (state == ST_RINGING);
  assign buzzer_out    = tone;

endmodule

// File: tb/tb_clock_time_controller.sv
// Directed bench for clock_time_controller: time carries, alarm-time stepping, ringing,
// buzzer gating, dismiss and asynchronous reset, each with hand-computed expectations.
module tb_clock_time_controller;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sec_tick = 1'b0, tone_pulse = 1'b0, sec_adj = 1'b0, min_adj = 1'b0;
  logic       hrs_adj = 1'b0, al_adj = 1'b0, al_toggle = 1'b0;
  logic [5:0] seconds, minutes, al_minutes;
  logic [3:0] hours, al_hours;
  logic       al_on, alarm_ringing, buzzer_out;

  int checks = 0;
  int errors = 0;

  // Stimulus bit masks: {sec_tick, tone_pulse, sec_adj, min_adj, hrs_adj, al_adj, al_toggle}
  localparam logic [6:0] P_NONE = 7'b0000000;
  localparam logic [6:0] P_TICK = 7'b1000000;
  localparam logic [6:0] P_TONE = 7'b0100000;
  localparam logic [6:0] P_SADJ = 7'b0010000;
  localparam logic [6:0] P_MADJ = 7'b0001000;
  localparam logic [6:0] P_HADJ = 7'b0000100;
  localparam logic [6:0] P_AADJ = 7'b0000010;
  localparam logic [6:0] P_TOGL = 7'b0000001;

  clock_time_controller #(
    .RING_SECONDS(60),
    .AL_MIN_STEP (10),
    .HOURS_MOD   (12)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sec_tick     (sec_tick),
    .tone_pulse   (tone_pulse),
    .sec_adj      (sec_adj),
    .min_adj      (min_adj),
    .hrs_adj      (hrs_adj),
    .al_adj       (al_adj),
    .al_toggle    (al_toggle),
    .seconds      (seconds),
    .minutes      (minutes),
    .hours        (hours),
    .al_minutes   (al_minutes),
    .al_hours     (al_hours),
    .al_on        (al_on),
    .alarm_ringing(alarm_ringing),
    .buzzer_out   (buzzer_out)
  );

  always #5 clk = ~clk;

  // Drive a pulse pattern for n consecutive cycles; outputs are readable on return (#1 after the edge).
  task automatic cyc(input logic [6:0] p, input int n);
    repeat (n) begin
      @(negedge clk);
      {sec_tick, tone_pulse, sec_adj, min_adj, hrs_adj, al_adj, al_toggle} = p;
      @(posedge clk);
      #1;
      {sec_tick, tone_pulse, sec_adj, min_adj, hrs_adj, al_adj, al_toggle} = P_NONE;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++;
    if ({seconds, minutes, hours, al_minutes, al_hours, al_on, alarm_ringing, buzzer_out} !== 35'd0) begin
      $display("FAIL reset_outputs: got %h expected 0",
               {seconds, minutes, hours, al_minutes, al_hours, al_on, alarm_ringing, buzzer_out});
      errors++;
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_sec_carry();
    do_reset();
    cyc(P_TICK, 59);
    checks++;
    if ({minutes, seconds} !== {6'd0, 6'd59}) begin
      $display("FAIL tick59: got m=%0d s=%0d expected m=0 s=59", minutes, seconds);
      errors++;
    end
    cyc(P_TICK, 1);
    checks++;
    if ({minutes, seconds} !== {6'd1, 6'd0}) begin
      $display("FAIL tick60_carry: got m=%0d s=%0d expected m=1 s=0", minutes, seconds);
      errors++;
    end
  endtask

  task automatic test_rollover();
    do_reset();
    cyc(P_HADJ, 11);
    cyc(P_MADJ, 59);
    cyc(P_SADJ, 59);
    checks++;
    if ({hours, minutes, seconds} !== {4'd11, 6'd59, 6'd59}) begin
      $display("FAIL preload: got %0d:%0d:%0d expected 11:59:59", hours, minutes, seconds);
      errors++;
    end
    cyc(P_TICK, 1);
    checks++;
    if ({hours, minutes, seconds} !== 16'd0) begin
      $display("FAIL full_rollover: got %0d:%0d:%0d expected 0:0:0", hours, minutes, seconds);
      errors++;
    end
    cyc(P_SADJ, 59);
    cyc(P_SADJ, 1);
    checks++;
    if ({hours, minutes, seconds} !== 16'd0) begin
      $display("FAIL sadj_wrap_no_carry: got %0d:%0d:%0d expected 0:0:0", hours, minutes, seconds);
      errors++;
    end
  endtask

  task automatic test_coincident();
    do_reset();
    cyc(P_SADJ, 59);
    cyc(P_TICK | P_MADJ, 1);
    checks++;
    if ({minutes, seconds} !== {6'd1, 6'd0}) begin
      $display("FAIL madj_with_carry: got m=%0d s=%0d expected m=1 s=0", minutes, seconds);
      errors++;
    end
    cyc(P_HADJ, 11);
    checks++;
    if (hours !== 4'd11) begin
      $display("FAIL hadj_to_11: got %0d expected 11", hours);
      errors++;
    end
    cyc(P_HADJ, 1);
    checks++;
    if (hours !== 4'd0) begin
      $display("FAIL hadj_wrap: got %0d expected 0", hours);
      errors++;
    end
  endtask

  task automatic test_alarm_adj();
    do_reset();
    cyc(P_AADJ, 5);
    checks++;
    if ({al_hours, al_minutes} !== {4'd0, 6'd50}) begin
      $display("FAIL al_adj5: got %0d:%0d expected 0:50", al_hours, al_minutes);
      errors++;
    end
    cyc(P_AADJ, 1);
    checks++;
    if ({al_hours, al_minutes, al_on} !== {4'd1, 6'd0, 1'b0}) begin
      $display("FAIL al_adj6_wrap: got %0d:%0d on=%0b expected 1:0 on=0", al_hours, al_minutes, al_on);
      errors++;
    end
  endtask

  // Alarm 00:10, armed, time driven to 00:10:00; leaves the DUT freshly RINGING.
  task automatic arm_and_ring();
    do_reset();
    cyc(P_AADJ, 1);
    cyc(P_TOGL, 1);
    checks++;
    if ({al_on, alarm_ringing} !== 2'b10) begin
      $display("FAIL armed: got on=%0b ring=%0b expected on=1 ring=0", al_on, alarm_ringing);
      errors++;
    end
    cyc(P_MADJ, 9);
    cyc(P_SADJ, 59);
    cyc(P_TICK, 1);
    checks++;
    if ({hours, minutes, seconds, alarm_ringing} !== {4'd0, 6'd10, 6'd0, 1'b0}) begin
      $display("FAIL match_cycle: got %0d:%0d:%0d ring=%0b expected 0:10:0 ring=0",
               hours, minutes, seconds, alarm_ringing);
      errors++;
    end
    cyc(P_NONE, 1);
    checks++;
    if ({alarm_ringing, buzzer_out} !== 2'b10) begin
      $display("FAIL ring_start: got ring=%0b buzz=%0b expected ring=1 buzz=0", alarm_ringing, buzzer_out);
      errors++;
    end
  endtask

  task automatic test_ring();
    logic [2:0] tone_seq;
    arm_and_ring();
    cyc(P_TONE, 1);
    tone_seq[2] = buzzer_out;
    cyc(P_TONE, 1);
    tone_seq[1] = buzzer_out;
    cyc(P_TONE, 1);
    tone_seq[0] = buzzer_out;
    checks++;
    if (tone_seq !== 3'b101) begin
      $display("FAIL tone_toggle: got %b expected 101", tone_seq);
      errors++;
    end
    cyc(P_AADJ, 1);
    checks++;
    if ({alarm_ringing, al_minutes} !== {1'b1, 6'd20}) begin
      $display("FAIL adjust_while_ringing: got ring=%0b alm=%0d expected ring=1 alm=20", alarm_ringing, al_minutes);
      errors++;
    end
    cyc(P_TICK, 1);
    cyc(P_NONE, 1);
    checks++;
    if (buzzer_out !== 1'b0) begin
      $display("FAIL off_phase_silent: got %0b expected 0", buzzer_out);
      errors++;
    end
    cyc(P_TONE, 1);
    checks++;
    if (buzzer_out !== 1'b0) begin
      $display("FAIL off_phase_no_toggle: got %0b expected 0", buzzer_out);
      errors++;
    end
    cyc(P_TICK, 58);
    checks++;
    if (alarm_ringing !== 1'b1) begin
      $display("FAIL ring_after_59: got %0b expected 1", alarm_ringing);
      errors++;
    end
    cyc(P_TICK, 1);
    checks++;
    if ({alarm_ringing, al_on, buzzer_out, minutes, seconds} !== {1'b0, 1'b1, 1'b0, 6'd11, 6'd0}) begin
      $display("FAIL ring_timeout: got ring=%0b on=%0b buzz=%0b m=%0d s=%0d expected ring=0 on=1 buzz=0 m=11 s=0",
               alarm_ringing, al_on, buzzer_out, minutes, seconds);
      errors++;
    end
  endtask

  task automatic test_dismiss_and_reset();
    arm_and_ring();
    cyc(P_TICK, 59);
    checks++;
    if (alarm_ringing !== 1'b1) begin
      $display("FAIL ring_before_final: got %0b expected 1", alarm_ringing);
      errors++;
    end
    cyc(P_TICK | P_TOGL, 1);
    checks++;
    if ({al_on, alarm_ringing, buzzer_out} !== 3'b000) begin
      $display("FAIL toggle_beats_timeout: got on=%0b ring=%0b buzz=%0b expected 000",
               al_on, alarm_ringing, buzzer_out);
      errors++;
    end
    arm_and_ring();
    cyc(P_TONE, 1);
    checks++;
    if (buzzer_out !== 1'b1) begin
      $display("FAIL buzz_before_reset: got %0b expected 1", buzzer_out);
      errors++;
    end
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({seconds, minutes, hours, al_minutes, al_hours, al_on, alarm_ringing, buzzer_out} !== 35'd0) begin
      $display("FAIL async_reset_mid_ring: got %h expected 0",
               {seconds, minutes, hours, al_minutes, al_hours, al_on, alarm_ringing, buzzer_out});
      errors++;
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_sec_carry();
    test_rollover();
    test_coincident();
    test_alarm_adj();
    test_ring();
    test_dismiss_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_time_controller.md
Name: clock_time_controller

Overview:
Timekeeping and alarm sequencer for the classic VGA clock. Owns the time-of-day registers (seconds/minutes/hours, 12-hour), the alarm-time registers and the alarm state machine. Arbitrates the 1 Hz tick against the debounced adjust buttons, and drives the buzzer. Outputs feed the clock renderer; inputs come from the button debouncers and the clock dividers.

Parameters:
RING_SECONDS, 60, sec_tick pulses spent in RINGING before auto-stop (1..63)
AL_MIN_STEP, 10, minutes added to the alarm time per al_adj pulse (1..59)
HOURS_MOD, 12, hour wrap modulus (hours 0..HOURS_MOD-1, max 16)

Ports:
clk  in  1  system clock (31.5 MHz)
reset_n  in  1  asynchronous active-low reset
sec_tick  in  1  one-cycle pulse at 1 Hz from the clock divider
tone_pulse  in  1  one-cycle pulse at 3150 Hz from the clock divider
sec_adj  in  1  debounced one-cycle pulse: advance seconds
min_adj  in  1  debounced one-cycle pulse: advance minutes
hrs_adj  in  1  debounced one-cycle pulse: advance hours
al_adj  in  1  debounced one-cycle pulse: advance alarm time by AL_MIN_STEP
al_toggle  in  1  debounced one-cycle pulse: alarm on/off / dismiss
seconds  out  6  current seconds, 0..59
minutes  out  6  current minutes, 0..59
hours  out  4  current hours, 0..HOURS_MOD-1
al_minutes  out  6  alarm minutes, 0..59
al_hours  out  4  alarm hours, 0..HOURS_MOD-1
al_on  out  1  alarm enabled (state != OFF); drives the bell symbol
alarm_ringing  out  1  state == RINGING
buzzer_out  out  1  square-wave tone to the external buzzer driver

Behaviour:
- Reset (reset_n low, asynchronous): all time and alarm registers = 0, state = OFF, ring_cnt = 0, beep_phase = 0, tone = 0, match_prev = 0. All outputs are therefore 0. Reset mid-ring silences the buzzer immediately.
- All outputs are registered. An input pulse on cycle N is visible on the outputs at cycle N+1.
- Seconds:
  - Increment by exactly 1 if sec_tick OR sec_adj; wraps 59->0.
  - A wrap produces a carry into minutes only if sec_tick was high that cycle. An adjust-only wrap does not carry.
- Minutes:
  - Increment by exactly 1 if min_adj OR seconds-carry; wraps 59->0.
  - Carries into hours only when the increment involved a seconds-carry.
  - Coincident min_adj and carry produce a single increment, not two.
- Hours: increment by 1 if hrs_adj OR minutes-carry; wraps HOURS_MOD-1 -> 0. Coincident sources again produce a single increment.
- Alarm time:
  - On al_adj, compute al_minutes + AL_MIN_STEP in 7 bits.
  - If the sum is >= 60: al_minutes = sum - 60, and al_hours increments, wrapping HOURS_MOD-1 -> 0.
  - Otherwise al_minutes = sum.
  - Allowed in any state.
- match = (hours==al_hours) && (minutes==al_minutes) && (seconds==0), evaluated on registered values. match_prev is match delayed by one cycle.
- Alarm FSM (2-bit state):
  - OFF: al_toggle -> ARMED.
  - ARMED:
    - al_toggle -> OFF (toggle has priority).
    - else match && !match_prev -> RINGING, with ring_cnt = 0 and beep_phase = 1.
  - RINGING:
    - al_toggle -> OFF (priority over timeout).
    - else on sec_tick with ring_cnt == RING_SECONDS-1 -> ARMED.
    - else on sec_tick: ring_cnt += 1 and beep_phase toggles.
  - Arming while match is already high does not trigger, because the rising edge has already passed.
- Buzzer:
  - tone toggles on each tone_pulse while (state==RINGING && beep_phase).
  - Otherwise tone is forced to 0 on the next cycle.
  - buzzer_out = tone. This gives 1575 Hz beeps, 1 s on / 1 s off.
- Adjusting the time or the alarm while RINGING does not stop ringing.

Test Plan:
1. Reset, then 59 sec_ticks -> seconds=59, minutes=0. One more tick -> seconds=0, minutes=1 on the next cycle.
2. Preload 11:59:59 via adjust pulses, then sec_tick -> 00:00:00. Separately, sec_adj at seconds=59 -> seconds=0 with minutes unchanged.
3. min_adj coincident with the tick that carries from 59 s -> minutes increments by 1 only. hrs_adj at hours=11 -> 0.
4. From reset, 5 al_adj pulses -> al_minutes=50, al_hours=0. A 6th pulse -> al_minutes=0, al_hours=1.
5. Alarm set to 00:10, al_toggle -> al_on=1; run time to 00:10:00:
   - alarm_ringing=1 on the cycle after match.
   - buzzer_out toggles on tone_pulse during odd seconds, is 0 during even seconds.
   - After 60 ticks, alarm_ringing=0 and al_on=1.
6. While RINGING, al_toggle coincident with the final sec_tick -> state OFF, al_on=0, buzzer_out=0. Separately, assert reset_n low mid-ring -> all outputs 0 asynchronously.
